// File: rtl/gnn_pkg.sv
// Shared constants, packed lane types and FSM state encoding for the GNN
// node scheduler.
package gnn_pkg;

   localparam int N_NODES = 4;
   localparam int LANES   = 4;
   localparam int NODE_W  = 2;
   localparam int FEAT_W  = 7;
   localparam int Z_W     = 13;
   localparam int A_W     = 15;
   localparam int OUT_W   = 21;

   typedef logic [NODE_W-1:0]            node_t;
   typedef logic [LANES-1:0][FEAT_W-1:0] feat_vec_t;
   typedef logic [LANES-1:0][Z_W-1:0]    z_vec_t;
   typedef logic [LANES-1:0][A_W-1:0]    a_vec_t;
   typedef logic [1:0][OUT_W-1:0]        out_pair_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      L1_ISSUE,
      L1_WAIT,
      AGG,
      L2_ISSUE,
      L2_WAIT,
      EMIT
   } state_t;

endpackage

// File: rtl/gnn_sched_if.sv
// Control, feature, datapath and result signals of the scheduler; the
// scheduler is the slave, its environment (host + datapath) the master.
interface gnn_sched_if;
   import gnn_pkg::*;

   logic      start;
   logic [15:0] adj;
   logic      busy;
   logic      done;
   logic      feat_valid;
   logic      feat_ready;
   feat_vec_t feat_data;
   feat_vec_t dnn_x;
   logic      dnn_in_ready;
   z_vec_t    dnn_z;
   a_vec_t    dnn_a;
   out_pair_t dnn_out;
   logic      dnn_out_ready;
   logic      res_valid;
   logic      res_ready;
   node_t     res_node;
   out_pair_t res_out;

   modport slave (
      input  start, adj, feat_valid, feat_data, dnn_z, dnn_out, dnn_out_ready, res_ready,
      output busy, done, feat_ready, dnn_x, dnn_in_ready, dnn_a, res_valid, res_node, res_out
   );

   modport master (
      output start, adj, feat_valid, feat_data, dnn_z, dnn_out, dnn_out_ready, res_ready,
      input  busy, done, feat_ready, dnn_x, dnn_in_ready, dnn_a, res_valid, res_node, res_out
   );

endinterface

// File: rtl/gnn_agg_unit.sv
// Four-lane neighbour accumulator: sum is the running total including this
// cycle's contribution, so the caller can store a finished row without delay.
module gnn_agg_unit
   import gnn_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   clear,
   input  logic   en,
   input  z_vec_t z_in,
   output a_vec_t sum
);

   a_vec_t acc;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      sum = '0;
      for (int k = 0; k < LANES; k++) begin
         sum[k] = (clear ? '0 : acc[k]) + (en ? A_W'(z_in[k]) : '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc <= '0;
      else        acc <= sum;
   end

endmodule

// File: rtl/gnn_sched.sv
// Sequences one 4-node GNN run: feature load, layer-1 issue per node,
// adjacency aggregation, layer-2 issue per node and result emission.
module gnn_sched
   import gnn_pkg::*;
#(
   parameter int N_NODES = gnn_pkg::N_NODES,
   parameter int L1_LAT  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   gnn_sched_if.slave bus
);

   localparam node_t      LAST_NODE = NODE_W'(N_NODES - 1);
   localparam logic [7:0] WAIT_LAST = 8'(L1_LAT - 1);

   state_t      state;
   node_t       node;
   logic [7:0]  wait_cnt;
   logic [3:0]  agg_idx;
   logic [15:0] adj_q;

   feat_vec_t feat_buf [N_NODES];
   z_vec_t    z_buf    [N_NODES];
   a_vec_t    acc_buf  [N_NODES];

   node_t  agg_i, agg_j;
   logic   agg_clear, agg_en, agg_store;
   a_vec_t agg_sum;

   // agg_idx walks {i,j}, which is also the bit position of adj[i*4+j].
   assign agg_i     = agg_idx[3:2];
   assign agg_j     = agg_idx[1:0];
   assign agg_clear = (state == AGG) && (agg_j == 2'd0);
   assign agg_en    = (state == AGG) && adj_q[agg_idx];
   assign agg_store = (state == AGG) && (agg_j == 2'd3);

   gnn_agg_unit u_agg (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (agg_clear),
      .en    (agg_en),
      .z_in  (z_buf[agg_j]),
      .sum   (agg_sum)
   );

   // NOTE: data buffers carry no reset; each slot is written before it is read within a run.
   always_ff @(posedge clk) begin
      if (state == LOAD && bus.feat_valid && bus.feat_ready) feat_buf[node] <= bus.feat_data;
      if (state == L1_WAIT && wait_cnt == WAIT_LAST)          z_buf[node]    <= bus.dnn_z;
      if (agg_store)                                           acc_buf[agg_i] <= agg_sum;
   end

   // NOTE: all state and registered outputs use non-blocking assignments so they sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         node             <= '0;
         wait_cnt         <= '0;
         agg_idx          <= '0;
         adj_q            <= '0;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.feat_ready   <= 1'b0;
         bus.dnn_in_ready <= 1'b0;
         bus.res_valid    <= 1'b0;
         bus.dnn_x        <= '0;
         bus.dnn_a        <= '0;
         bus.res_out      <= '0;
         bus.res_node     <= '0;
      end else begin
         bus.done         <= 1'b0;
         bus.dnn_in_ready <= 1'b0;
         unique case (state)
            IDLE: if (bus.start) begin
               adj_q          <= bus.adj;
               bus.busy       <= 1'b1;
               bus.feat_ready <= 1'b1;
               node           <= '0;
               state          <= LOAD;
            end
            LOAD: if (bus.feat_valid && bus.feat_ready) begin
               if (node == LAST_NODE) begin
                  bus.feat_ready   <= 1'b0;
                  node             <= '0;
                  bus.dnn_x        <= feat_buf[0];
                  bus.dnn_in_ready <= 1'b1;
                  state            <= L1_ISSUE;
               end else begin
                  node <= node + 1'b1;
               end
            end
            L1_ISSUE: begin
               wait_cnt <= '0;
               state    <= L1_WAIT;
            end
            L1_WAIT: if (wait_cnt == WAIT_LAST) begin
               if (node == LAST_NODE) begin
                  node    <= '0;
                  agg_idx <= '0;
                  state   <= AGG;
               end else begin
                  node             <= node + 1'b1;
                  bus.dnn_x        <= feat_buf[node + 1'b1];
                  bus.dnn_in_ready <= 1'b1;
                  state            <= L1_ISSUE;
               end
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
            AGG: begin
               agg_idx <= agg_idx + 1'b1;
               if (agg_idx == 4'd15) begin
                  bus.dnn_a        <= acc_buf[0];
                  bus.dnn_in_ready <= 1'b1;
                  state            <= L2_ISSUE;
               end
            end
            L2_ISSUE: state <= L2_WAIT;
            L2_WAIT: if (bus.dnn_out_ready) begin
               bus.res_out   <= bus.dnn_out;
               bus.res_node  <= node;
               bus.res_valid <= 1'b1;
               state         <= EMIT;
            end
            EMIT: if (bus.res_ready) begin
               bus.res_valid <= 1'b0;
               if (node == LAST_NODE) begin
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  node     <= '0;
                  state    <= IDLE;
               end else begin
                  node             <= node + 1'b1;
                  bus.dnn_a        <= acc_buf[node + 1'b1];
                  bus.dnn_in_ready <= 1'b1;
                  state            <= L2_ISSUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gnn_sched.sv
// Randomized bench for gnn_sched: models the host and the two-layer datapath
// and compares every aggregate and result against direct neighbour sums.
module tb_gnn_sched;
   import gnn_pkg::*;

   localparam int L1_LAT = 2;
   localparam int L2_LAT = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   int          z_tab [4][4];
   logic [27:0] feat_tab [4];
   logic [15:0] adj_cur;

   gnn_sched_if bus ();

   gnn_sched #(.N_NODES(4), .L1_LAT(L1_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.start         = 1'b0;
      bus.adj           = '0;
      bus.feat_valid    = 1'b0;
      bus.feat_data     = '0;
      bus.dnn_z         = '0;
      bus.dnn_out       = '0;
      bus.dnn_out_ready = 1'b0;
      bus.res_ready     = 1'b0;
   endtask

   // Aggregate of node i: plain sum of the z vectors of all neighbours j.
   function automatic logic [59:0] a_pack(input int i);
      logic [59:0] v;
      int s;
      v = '0;
      for (int k = 0; k < 4; k++) begin
         s = 0;
         for (int j = 0; j < 4; j++)
            if (adj_cur[i*4+j]) s += z_tab[j][k];
         v[k*15 +: 15] = 15'(s);
      end
      return v;
   endfunction

   function automatic logic [51:0] z_pack(input int j);
      logic [51:0] v;
      v = '0;
      for (int k = 0; k < 4; k++) v[k*13 +: 13] = 13'(z_tab[j][k]);
      return v;
   endfunction

   task automatic wait_issue(input string tag, input int budget, output int cycles, output bit ok);
      ok     = 1'b0;
      cycles = 0;
      for (int c = 0; c <= budget; c++) begin
         if (bus.dnn_in_ready) begin
            ok     = 1'b1;
            cycles = c;
            break;
         end
         if (c < budget) tick();
      end
      if (!ok) check({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic run_graph(input int stall, input bit abort_in_agg);
      bit          ok;
      int          cyc;
      int          busy_seen;
      logic [41:0] out_v;

      for (int n = 0; n < 4; n++) feat_tab[n] = 28'($urandom);

      bus.adj   = adj_cur;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.adj   = 16'($urandom);
      check("busy_after_start", 64'(bus.busy), 64'd1);

      for (int n = 0; n < 4; n++) begin
         repeat ($urandom_range(0, 2)) begin
            bus.feat_valid = 1'b0;
            bus.feat_data  = 28'($urandom);
            tick();
         end
         check("feat_ready_in_load", 64'(bus.feat_ready), 64'd1);
         bus.feat_valid = 1'b1;
         bus.feat_data  = feat_tab[n];
         tick();
      end
      bus.feat_valid = 1'b0;
      check("feat_ready_after_load", 64'(bus.feat_ready), 64'd0);

      for (int n = 0; n < 4; n++) begin
         wait_issue("l1_issue", 20, cyc, ok);
         if (!ok) return;
         check("dnn_x", 64'(bus.dnn_x), 64'(feat_tab[n]));
         tick();
         check("l1_pulse_width", 64'(bus.dnn_in_ready), 64'd0);
         repeat (L1_LAT - 1) begin
            check("dnn_x_hold", 64'(bus.dnn_x), 64'(feat_tab[n]));
            bus.dnn_out_ready = 1'b1;
            bus.dnn_out       = 42'({$urandom, $urandom});
            tick();
         end
         bus.dnn_z = z_pack(n);
         bus.start = 1'b1;
         tick();
         bus.dnn_z         = 52'({$urandom, $urandom});
         bus.start         = 1'b0;
         bus.dnn_out_ready = 1'b0;
      end

      if (abort_in_agg) begin
         repeat (7) tick();
         rst_n = 1'b0;
         #1;
         check("rst_busy", 64'(bus.busy), 64'd0);
         check("rst_res_valid", 64'(bus.res_valid), 64'd0);
         check("rst_dnn_in_ready", 64'(bus.dnn_in_ready), 64'd0);
         check("rst_dnn_x", 64'(bus.dnn_x), 64'd0);
         drive_idle();
         repeat (2) @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         busy_seen = 0;
         repeat (30) begin
            tick();
            if (bus.res_valid || bus.dnn_in_ready || bus.busy) busy_seen++;
         end
         check("quiet_after_reset", 64'(busy_seen), 64'd0);
         return;
      end

      for (int n = 0; n < 4; n++) begin
         wait_issue("l2_issue", 40, cyc, ok);
         if (!ok) return;
         if (n == 0) check("agg_cycles", 64'(cyc), 64'd16);
         check("dnn_a", 64'(bus.dnn_a), 64'(a_pack(n)));
         out_v = 42'({$urandom, $urandom});
         tick();
         check("l2_pulse_width", 64'(bus.dnn_in_ready), 64'd0);
         repeat (L2_LAT - 1) begin
            check("dnn_a_hold", 64'(bus.dnn_a), 64'(a_pack(n)));
            check("res_valid_wait", 64'(bus.res_valid), 64'd0);
            tick();
         end
         bus.dnn_out_ready = 1'b1;
         bus.dnn_out       = out_v;
         tick();
         bus.dnn_out_ready = 1'b0;
         bus.dnn_out       = 42'({$urandom, $urandom});
         check("res_valid", 64'(bus.res_valid), 64'd1);
         check("res_node", 64'(bus.res_node), 64'(n));
         check("res_out", 64'(bus.res_out), 64'(out_v));

         repeat (stall) begin
            bus.dnn_out_ready = 1'b1;
            bus.dnn_out       = 42'({$urandom, $urandom});
            bus.start         = 1'b1;
            tick();
            check("stall_res_valid", 64'(bus.res_valid), 64'd1);
            check("stall_res_node", 64'(bus.res_node), 64'(n));
            check("stall_res_out", 64'(bus.res_out), 64'(out_v));
            check("stall_done", 64'(bus.done), 64'd0);
         end
         bus.dnn_out_ready = 1'b0;
         bus.start         = 1'b0;

         bus.res_ready = 1'b1;
         tick();
         bus.res_ready = 1'b0;
         check("res_valid_after_hs", 64'(bus.res_valid), 64'd0);
         if (n == 3) begin
            check("done_pulse", 64'(bus.done), 64'd1);
            check("busy_at_done", 64'(bus.busy), 64'd0);
         end else begin
            check("done_early", 64'(bus.done), 64'd0);
         end
      end

      tick();
      check("done_one_cycle", 64'(bus.done), 64'd0);
      busy_seen = 0;
      repeat (3) begin
         tick();
         if (bus.done || bus.busy || bus.res_valid) busy_seen++;
      end
      check("idle_after_run", 64'(busy_seen), 64'd0);
   endtask

   task automatic rand_z(input int max_val);
      for (int j = 0; j < 4; j++)
         for (int k = 0; k < 4; k++) z_tab[j][k] = int'($urandom_range(0, max_val));
   endtask

   initial begin
      drive_idle();
      rst_n = 1'b0;
      #12;
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_feat_ready", 64'(bus.feat_ready), 64'd0);
      check("reset_dnn_in_ready", 64'(bus.dnn_in_ready), 64'd0);
      check("reset_res_valid", 64'(bus.res_valid), 64'd0);
      check("reset_dnn_x", 64'(bus.dnn_x), 64'd0);
      check("reset_dnn_a", 64'(bus.dnn_a), 64'd0);
      check("reset_res_out", 64'(bus.res_out), 64'd0);
      check("reset_res_node", 64'(bus.res_node), 64'd0);
      rst_n = 1'b1;
      tick();

      // Full adjacency with z[j] lanes = j+1: every aggregate lane is 10.
      adj_cur = 16'hFFFF;
      for (int j = 0; j < 4; j++)
         for (int k = 0; k < 4; k++) z_tab[j][k] = j + 1;
      run_graph(0, 1'b0);

      adj_cur = 16'h8421;
      rand_z(4095);
      run_graph(1, 1'b0);

      adj_cur = 16'h8021;
      rand_z(4095);
      run_graph(0, 1'b0);

      // Saturated inputs reach 16380 without wrapping; EMIT stalled 5 cycles.
      adj_cur = 16'hFFFF;
      for (int j = 0; j < 4; j++)
         for (int k = 0; k < 4; k++) z_tab[j][k] = 4095;
      run_graph(5, 1'b0);

      adj_cur = 16'($urandom);
      rand_z(4095);
      run_graph(0, 1'b1);

      for (int r = 0; r < 5; r++) begin
         adj_cur = (r == 0) ? 16'h0000 : 16'($urandom);
         rand_z(4095);
         run_graph(int'($urandom_range(0, 3)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gnn_sched.md
GNN_SCHED -- requirements
Module: gnn_sched

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- N_NODES, 4, graph nodes per run (fixed at 4 this revision).
- L1_LAT, 2, cycles from dnn_in_ready to valid dnn_z.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  run request, sampled in IDLE only.
- adj  in  16  adjacency, bit i*4+j = node i aggregates node j; captured on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last result handshake.
- feat_valid  in  1  node feature word valid.
- feat_ready  out  1  high only in LOAD.
- feat_data  in  28  four signed 7-bit features {x3,x2,x1,x0}.
- dnn_x  out  28  features to datapath layer-1 inputs.
- dnn_in_ready  out  1  one-cycle issue pulse to datapath.
- dnn_z  in  52  four unsigned 13-bit ReLU outputs {z7,z6,z5,z4}.
- dnn_a  out  60  four signed 15-bit aggregates {a7,a6,a5,a4}.
- dnn_out  in  42  {out1,out0}, signed 21-bit each.
- dnn_out_ready  in  1  layer-2 result strobe.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_node  out  2  node index of result.
- res_out  out  42  {out1,out0} captured for res_node.

Function
REQ-003 SHALL implement states IDLE, LOAD, L1_ISSUE, L1_WAIT, AGG, L2_ISSUE, L2_WAIT, EMIT.
REQ-004 IDLE: start=1 SHALL capture adj, set busy, enter LOAD next cycle; start in any other state SHALL be ignored.
REQ-005 LOAD: each feat_valid&feat_ready SHALL store feat_data into feature buffer slot n (n=0..3 ascending); after slot 3, enter L1_ISSUE.
REQ-006 L1_ISSUE: drive dnn_x = feature[n], pulse dnn_in_ready for exactly one cycle, enter L1_WAIT; dnn_x SHALL hold stable through L1_WAIT.
REQ-007 L1_WAIT: after exactly L1_LAT cycles, capture dnn_z into z buffer slot n; next node or, after node 3, AGG.
REQ-008 AGG: SHALL take exactly 16 cycles, one (i,j) pair per cycle, i outer, j inner; if adj[i*4+j] then acc[i][k] += z[j][k] for each lane k, accumulators cleared at j=0.
REQ-009 Aggregation SHALL be 15-bit; max 4*4095 = 16380, no overflow or saturation logic needed; zero adjacency row SHALL yield all-zero aggregate.
REQ-010 L2_ISSUE: drive dnn_a = acc[n], pulse dnn_in_ready one cycle, enter L2_WAIT; dnn_a held stable until dnn_out_ready.
REQ-011 L2_WAIT: on dnn_out_ready capture dnn_out into res_out, res_node = n, enter EMIT.
REQ-012 EMIT: res_valid=1; res_out/res_node SHALL stay stable until res_ready; on handshake next node to L2_ISSUE, or after node 3 pulse done, clear busy, return IDLE.
REQ-013 dnn_in_ready SHALL never assert outside L1_ISSUE/L2_ISSUE; dnn_out_ready outside L2_WAIT SHALL be ignored.
REQ-014 Weights SHALL NOT be driven by this block; they are static during busy.

Reset
REQ-015 rst_n low SHALL asynchronously force IDLE, node counter 0, busy/done/feat_ready/dnn_in_ready/res_valid = 0, dnn_x/dnn_a/res_out/res_node = 0.
REQ-016 Buffers (feature, z, acc) need no reset; reset mid-run SHALL abandon the run, with no result emitted after release until a new start.

Structure
REQ-017 gnn_pkg SHALL hold N_NODES, widths (FEAT_W=7, Z_W=13, A_W=15, OUT_W=21), and the state enum.
REQ-018 Lane accumulate SHALL be sub-module gnn_agg_unit (4 lanes, clear, enable, 13-bit in, 15-bit acc).

Verification (bench models datapath: dnn_z returned L1_LAT after issue; dnn_out_ready 3 cycles after L2 issue)
REQ-019 adj=16'hFFFF, z[j] lanes all j+1 -> every dnn_a lane = 10 for all four nodes.
REQ-020 adj=16'h8421 (self only) -> dnn_a for node i equals z[i]; adj row 2 = 0 -> node 2 dnn_a = 0.
REQ-021 All z lanes = 4095, adj=16'hFFFF -> every lane 16380, no wrap.
REQ-022 res_ready low 5 cycles in EMIT -> res_valid stays 1, res_out/res_node unchanged; done pulses once, 1 cycle after node 3 handshake.
REQ-023 rst_n low during AGG cycle 7 -> busy=0, res_valid=0 immediately; after release no res_valid until new start; start during busy ignored.
